// File: rtl/clk_div_ratio_meter_pkg.sv
// Shared definitions for the divided-clock measurement blocks.
//
// Contents:
//   meas_state_e    - 2-bit state encoding of the ratio meter FSM
//   DEF_CNT_W       - default width of the high/low/period counters
//   DEF_LOCK_CNT    - default number of equal periods needed for lock
//   DEF_SYNC_STAGES - default synchronizer depth
//   ABS_W           - working width of abs_diff (counters up to 32 bits)
//   abs_diff()      - unsigned absolute difference of two zero-extended values

package clk_meas_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_LOCK_CNT    = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int ABS_W           = 33;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEAS_HIGH = 2'd2,
        ST_MEAS_LOW  = 2'd3
    } meas_state_e;

    // Callers zero-extend their operands to ABS_W bits. The subtraction is
    // ordered so that it never wraps, which gives |a - b| directly.
    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clk_div_ratio_meter_sync_edge_det.sv
// Synchronizer plus edge detector for a slow asynchronous level.
// It can be reused by any monitor that watches a foreign clock or strobe.
//
// Ports:
//   clk_in - sampling clock, rising edge
//   rst_n  - asynchronous active-low reset, clears every flop to 0
//   d      - asynchronous input level
//   q_sync - synchronized level (last synchronizer stage)
//   rise   - q_sync is 1 this cycle and was 0 the cycle before
//   fall   - q_sync is 0 this cycle and was 1 the cycle before
//
// Parameter SYNC_STAGES (at least 2) sets the synchronizer depth. The edge
// outputs are combinational from the delay flop, so a change on d shows up
// on rise/fall SYNC_STAGES cycles later. Logic that registers rise/fall acts
// on the change SYNC_STAGES+1 cycles after it arrives.

module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic q_sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Shift the input through the synchronizer. The extra delay flop holds
    // the previous synchronized level for edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = q_sync & ~dly_q;
    assign fall   = ~q_sync & dly_q;

endmodule

// File: rtl/clk_div_ratio_meter.sv
// Receive-side checker for a divided clock. It measures the high time, low
// time and period of div_clk_in in clk_in cycles. It reports odd/even ratio
// and duty symmetry, and declares lock once the period is stable.
//
// Ports:
//   clk_in     - reference clock, all logic on its rising edge
//   rst_n      - asynchronous active-low reset
//   en         - measurement enable; 0 returns to idle and clears lock state
//   div_clk_in - divided clock under test, asynchronous to clk_in
//   high_cnt   - cycles high in the last published measurement
//   low_cnt    - cycles low in the last published measurement
//   period     - high_cnt + low_cnt, one bit wider so it never truncates
//   meas_valid - one-cycle pulse when high_cnt/low_cnt/period update
//   is_odd     - period[0] of the last measurement
//   duty_ok    - |high_cnt - low_cnt| <= 1
//   locked     - LOCK_CNT consecutive identical periods seen
//   overflow   - sticky until reset or en=0: a phase counter saturated

module clk_div_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_CNT    = DEF_LOCK_CNT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_clk_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             is_odd,
    output logic             duty_ok,
    output logic             locked,
    output logic             overflow
);

    localparam int               LK_W      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // One below the saturated value. A phase counter that still sees no edge
    // here would reach 2^CNT_W-1 on this edge, so the measurement is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST  = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [LK_W-1:0]  LOCK_FULL = LK_W'(LOCK_CNT);
    localparam logic [LK_W-1:0]  LOCK_ONE  = LK_W'(1);

    meas_state_e      state;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic [LK_W-1:0]  lock_cnt;
    logic [LK_W-1:0]  lock_next;
    logic             div_sync;
    logic             div_rise;
    logic             div_fall;
    logic [CNT_W:0]   new_period;
    logic [ABS_W-1:0] new_diff;
    logic             new_duty_ok;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .d     (div_clk_in),
        .q_sync(div_sync),
        .rise  (div_rise),
        .fall  (div_fall)
    );

    // Values that would be published on the closing rise. lock_cnt == 0
    // marks the first measurement after idle or overflow. That measurement
    // always starts the run at 1, whatever period the register still holds.
    always_comb begin
        new_period  = {1'b0, hcnt} + {1'b0, lcnt};
        new_diff    = abs_diff(ABS_W'(hcnt), ABS_W'(lcnt));
        new_duty_ok = (new_diff <= ABS_W'(1));
        lock_next   = LOCK_ONE;
        if ((lock_cnt != '0) && (new_period == period)) begin
            lock_next = (lock_cnt == LOCK_FULL) ? LOCK_FULL : (lock_cnt + LOCK_ONE);
        end
    end

    // Measurement FSM. The rise that closes one measurement also opens the
    // next, so measurements run back-to-back. Dropping en overrides every
    // state, including a rise on the same edge. The published result
    // registers keep their last values across en=0.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hcnt       <= '0;
            lcnt       <= '0;
            lock_cnt   <= '0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            is_odd     <= 1'b0;
            duty_ok    <= 1'b0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                state    <= ST_IDLE;
                hcnt     <= '0;
                lcnt     <= '0;
                lock_cnt <= '0;
                locked   <= 1'b0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_WAIT_RISE;
                    end
                    ST_WAIT_RISE: begin
                        if (div_rise) begin
                            hcnt  <= CNT_ONE;
                            state <= ST_MEAS_HIGH;
                        end
                    end
                    ST_MEAS_HIGH: begin
                        if (div_fall) begin
                            lcnt  <= CNT_ONE;
                            state <= ST_MEAS_LOW;
                        end else if (div_sync) begin
                            if (hcnt == CNT_LAST) begin
                                overflow <= 1'b1;
                                locked   <= 1'b0;
                                lock_cnt <= '0;
                                state    <= ST_WAIT_RISE;
                            end else begin
                                hcnt <= hcnt + CNT_ONE;
                            end
                        end
                    end
                    ST_MEAS_LOW: begin
                        if (div_rise) begin
                            high_cnt   <= hcnt;
                            low_cnt    <= lcnt;
                            period     <= new_period;
                            is_odd     <= new_period[0];
                            duty_ok    <= new_duty_ok;
                            meas_valid <= 1'b1;
                            lock_cnt   <= lock_next;
                            locked     <= (lock_next == LOCK_FULL);
                            hcnt       <= CNT_ONE;
                            state      <= ST_MEAS_HIGH;
                        end else if (!div_sync) begin
                            if (lcnt == CNT_LAST) begin
                                overflow <= 1'b1;
                                locked   <= 1'b0;
                                lock_cnt <= '0;
                                state    <= ST_WAIT_RISE;
                            end else begin
                                lcnt <= lcnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ratio_meter.sv
// Directed testbench for clk_div_ratio_meter. It uses CNT_W=4 so that
// saturation is reachable within a few cycles. div_clk_in is driven one
// time unit after each clk_in rising edge. A monitor records every
// meas_valid pulse at the falling edge, and each test task compares the
// recorded results against hand-computed values.

module tb_clk_div_ratio_meter;

    localparam int CNT_W = 4;

    logic             clk_in;
    logic             rst_n;
    logic             en;
    logic             div_clk_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             is_odd;
    logic             duty_ok;
    logic             locked;
    logic             overflow;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc_cnt      = 0;

    typedef struct {
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] l;
        logic [CNT_W:0]   p;
        logic             odd;
        logic             duty;
        logic             lk;
        logic             ovf;
        int               cyc;
    } meas_t;

    meas_t mq[$];

    clk_div_ratio_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .LOCK_CNT   (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .div_clk_in(div_clk_in),
        .high_cnt  (high_cnt),
        .low_cnt   (low_cnt),
        .period    (period),
        .meas_valid(meas_valid),
        .is_odd    (is_odd),
        .duty_ok   (duty_ok),
        .locked    (locked),
        .overflow  (overflow)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc_cnt++;

    // Record every published measurement, sampled away from the active edge.
    always @(negedge clk_in) begin
        meas_t m;
        if (meas_valid === 1'b1) begin
            m.h    = high_cnt;
            m.l    = low_cnt;
            m.p    = period;
            m.odd  = is_odd;
            m.duty = duty_ok;
            m.lk   = locked;
            m.ovf  = overflow;
            m.cyc  = cyc_cnt;
            mq.push_back(m);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Drive n periods of h cycles high followed by l cycles low.
    task automatic drive_wave(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            div_clk_in = 1'b1;
            tick(h);
            div_clk_in = 1'b0;
            tick(l);
        end
    endtask

    // Raise the input once more to close the last measurement, then let it
    // propagate through the synchronizer.
    task automatic close_wave();
        div_clk_in = 1'b1;
        tick(6);
    endtask

    // Toggle en to return the DUT to a fresh measurement state.
    task automatic restart();
        en         = 1'b0;
        div_clk_in = 1'b0;
        tick(2);
        en = 1'b1;
        tick(4);
        mq.delete();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        div_clk_in = 1'b0;
        tick(3);
        tests_run++; if (high_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_high_cnt: got %0d expected 0", high_cnt); end
        tests_run++; if (low_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_low_cnt: got %0d expected 0", low_cnt); end
        tests_run++; if (period !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_period: got %0d expected 0", period); end
        tests_run++; if (meas_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_meas_valid: got %b expected 0", meas_valid); end
        tests_run++; if (is_odd !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_is_odd: got %b expected 0", is_odd); end
        tests_run++; if (duty_ok !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_duty_ok: got %b expected 0", duty_ok); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_div5();
        meas_t m;
        restart();
        drive_wave(3, 2, 6);
        close_wave();
        tests_run++; if (mq.size() != 6) begin tests_failed++; $display("[TB] FAIL div5_count: got %0d expected 6", mq.size()); end
        for (int i = 0; i < mq.size(); i++) begin
            m = mq[i];
            tests_run++; if (m.h !== 4'd3) begin tests_failed++; $display("[TB] FAIL div5_high[%0d]: got %0d expected 3", i, m.h); end
            tests_run++; if (m.l !== 4'd2) begin tests_failed++; $display("[TB] FAIL div5_low[%0d]: got %0d expected 2", i, m.l); end
            tests_run++; if (m.p !== 5'd5) begin tests_failed++; $display("[TB] FAIL div5_period[%0d]: got %0d expected 5", i, m.p); end
            tests_run++; if (m.odd !== 1'b1) begin tests_failed++; $display("[TB] FAIL div5_is_odd[%0d]: got %b expected 1", i, m.odd); end
            tests_run++; if (m.duty !== 1'b1) begin tests_failed++; $display("[TB] FAIL div5_duty_ok[%0d]: got %b expected 1", i, m.duty); end
            tests_run++; if (m.lk !== (i >= 3)) begin tests_failed++; $display("[TB] FAIL div5_locked[%0d]: got %b expected %b", i, m.lk, (i >= 3)); end
            if (i > 0) begin
                tests_run++; if (m.cyc - mq[i-1].cyc != 5) begin tests_failed++; $display("[TB] FAIL div5_spacing[%0d]: got %0d expected 5", i, m.cyc - mq[i-1].cyc); end
            end
        end
    endtask

    task automatic test_div2();
        meas_t m;
        restart();
        drive_wave(1, 1, 8);
        close_wave();
        tests_run++; if (mq.size() != 8) begin tests_failed++; $display("[TB] FAIL div2_count: got %0d expected 8", mq.size()); end
        for (int i = 0; i < mq.size(); i++) begin
            m = mq[i];
            tests_run++; if (m.p !== 5'd2) begin tests_failed++; $display("[TB] FAIL div2_period[%0d]: got %0d expected 2", i, m.p); end
            tests_run++; if (m.odd !== 1'b0) begin tests_failed++; $display("[TB] FAIL div2_is_odd[%0d]: got %b expected 0", i, m.odd); end
            tests_run++; if (m.duty !== 1'b1) begin tests_failed++; $display("[TB] FAIL div2_duty_ok[%0d]: got %b expected 1", i, m.duty); end
            tests_run++; if (m.lk !== (i >= 3)) begin tests_failed++; $display("[TB] FAIL div2_locked[%0d]: got %b expected %b", i, m.lk, (i >= 3)); end
            if (i > 0) begin
                tests_run++; if (m.cyc - mq[i-1].cyc != 2) begin tests_failed++; $display("[TB] FAIL div2_spacing[%0d]: got %0d expected 2", i, m.cyc - mq[i-1].cyc); end
            end
        end
    endtask

    task automatic test_ratio_change();
        meas_t m;
        int    exp_p;
        int    exp_h;
        logic  exp_lk;
        restart();
        drive_wave(3, 2, 5);
        drive_wave(4, 3, 5);
        close_wave();
        tests_run++; if (mq.size() != 10) begin tests_failed++; $display("[TB] FAIL ratio_count: got %0d expected 10", mq.size()); end
        for (int i = 0; i < mq.size(); i++) begin
            m      = mq[i];
            exp_p  = (i < 5) ? 5 : 7;
            exp_h  = (i < 5) ? 3 : 4;
            exp_lk = (i == 3) || (i == 4) || (i >= 8);
            tests_run++; if (int'(m.p) != exp_p) begin tests_failed++; $display("[TB] FAIL ratio_period[%0d]: got %0d expected %0d", i, m.p, exp_p); end
            tests_run++; if (int'(m.h) != exp_h) begin tests_failed++; $display("[TB] FAIL ratio_high[%0d]: got %0d expected %0d", i, m.h, exp_h); end
            tests_run++; if (m.lk !== exp_lk) begin tests_failed++; $display("[TB] FAIL ratio_locked[%0d]: got %b expected %b", i, m.lk, exp_lk); end
        end
    endtask

    task automatic test_skewed();
        meas_t m;
        restart();
        drive_wave(4, 1, 3);
        close_wave();
        tests_run++; if (mq.size() != 3) begin tests_failed++; $display("[TB] FAIL skew_count: got %0d expected 3", mq.size()); end
        for (int i = 0; i < mq.size(); i++) begin
            m = mq[i];
            tests_run++; if (m.h !== 4'd4) begin tests_failed++; $display("[TB] FAIL skew_high[%0d]: got %0d expected 4", i, m.h); end
            tests_run++; if (m.l !== 4'd1) begin tests_failed++; $display("[TB] FAIL skew_low[%0d]: got %0d expected 1", i, m.l); end
            tests_run++; if (m.p !== 5'd5) begin tests_failed++; $display("[TB] FAIL skew_period[%0d]: got %0d expected 5", i, m.p); end
            tests_run++; if (m.odd !== 1'b1) begin tests_failed++; $display("[TB] FAIL skew_is_odd[%0d]: got %b expected 1", i, m.odd); end
            tests_run++; if (m.duty !== 1'b0) begin tests_failed++; $display("[TB] FAIL skew_duty_ok[%0d]: got %b expected 0", i, m.duty); end
        end
    endtask

    task automatic test_overflow();
        meas_t m;
        restart();
        div_clk_in = 1'b1;
        tick(10);
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_early: got %b expected 0", overflow); end
        tick(15);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
        tests_run++; if (mq.size() != 0) begin tests_failed++; $display("[TB] FAIL ovf_no_valid: got %0d expected 0", mq.size()); end
        div_clk_in = 1'b0;
        tick(1);
        drive_wave(2, 1, 4);
        close_wave();
        tests_run++; if (mq.size() != 4) begin tests_failed++; $display("[TB] FAIL ovf_resume_count: got %0d expected 4", mq.size()); end
        for (int i = 0; i < mq.size(); i++) begin
            m = mq[i];
            tests_run++; if (m.p !== 5'd3) begin tests_failed++; $display("[TB] FAIL ovf_period[%0d]: got %0d expected 3", i, m.p); end
            tests_run++; if (m.h !== 4'd2) begin tests_failed++; $display("[TB] FAIL ovf_high[%0d]: got %0d expected 2", i, m.h); end
            tests_run++; if (m.duty !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_duty_ok[%0d]: got %b expected 1", i, m.duty); end
            tests_run++; if (m.ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_sticky[%0d]: got %b expected 1", i, m.ovf); end
            tests_run++; if (m.lk !== (i >= 3)) begin tests_failed++; $display("[TB] FAIL ovf_locked[%0d]: got %b expected %b", i, m.lk, (i >= 3)); end
        end
        en = 1'b0;
        tick(1);
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_off_overflow: got %b expected 0", overflow); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_off_locked: got %b expected 0", locked); end
        tests_run++; if (high_cnt !== 4'd2) begin tests_failed++; $display("[TB] FAIL en_off_hold_high: got %0d expected 2", high_cnt); end
        tests_run++; if (period !== 5'd3) begin tests_failed++; $display("[TB] FAIL en_off_hold_period: got %0d expected 3", period); end
        en = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid();
        meas_t m;
        restart();
        div_clk_in = 1'b1;
        tick(3);
        div_clk_in = 1'b0;
        tick(5);
        rst_n = 1'b0;
        @(negedge clk_in);
        tests_run++; if (high_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL rstmid_high_cnt: got %0d expected 0", high_cnt); end
        tests_run++; if (period !== 5'd0) begin tests_failed++; $display("[TB] FAIL rstmid_period: got %0d expected 0", period); end
        tests_run++; if (is_odd !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_is_odd: got %b expected 0", is_odd); end
        tests_run++; if (duty_ok !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_duty_ok: got %b expected 0", duty_ok); end
        tick(2);
        rst_n = 1'b1;
        tick(3);
        mq.delete();
        drive_wave(3, 2, 2);
        close_wave();
        tests_run++; if (mq.size() != 2) begin tests_failed++; $display("[TB] FAIL rstmid_count: got %0d expected 2", mq.size()); end
        for (int i = 0; i < mq.size(); i++) begin
            m = mq[i];
            tests_run++; if (m.p !== 5'd5) begin tests_failed++; $display("[TB] FAIL rstmid_period[%0d]: got %0d expected 5", i, m.p); end
            tests_run++; if (m.h !== 4'd3) begin tests_failed++; $display("[TB] FAIL rstmid_high[%0d]: got %0d expected 3", i, m.h); end
        end
    endtask

    initial begin
        test_reset();
        test_div5();
        test_div2();
        test_ratio_change();
        test_skewed();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
